// File: rtl/rst_seq_ctrl.sv
// Reset/run sequencer: drives a programmable train of DUT reset pulses, then a
// bounded run window that ends by halt, timeout, or restart on request.
module rst_seq_ctrl #(
   parameter int N_PULSES     = 2,
   parameter int FIRST_CYC    = 2,
   parameter int GAP_CYC      = 2,
   parameter int REASSERT_CYC = 10,
   parameter int RUN_CYC      = 100,
   parameter int CNT_W        = 16,
   parameter bit RST_POL      = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             halt_i,
   input  logic             rerun_i,
   output logic             dut_rst,
   output logic [1:0]       phase,
   output logic [CNT_W-1:0] pulse_idx,
   output logic [CNT_W-1:0] run_cycles,
   output logic             done,
   output logic             halted,
   output logic             timeout
);

   typedef enum logic [1:0] {
      S_ASSERT = 2'd0,
      S_GAP    = 2'd1,
      S_RUN    = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] FIRST_LAST = CNT_W'(FIRST_CYC - 1);
   localparam logic [CNT_W-1:0] REAS_LAST  = CNT_W'(REASSERT_CYC - 1);
   localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYC - 1);
   localparam logic [CNT_W-1:0] RUN_LAST   = CNT_W'(RUN_CYC - 1);
   localparam logic [CNT_W-1:0] LAST_PULSE = CNT_W'(N_PULSES - 1);
   localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] len_last;

   // Only the first pulse uses the short hold length.
   assign len_last = (pulse_idx == '0) ? FIRST_LAST : REAS_LAST;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_ASSERT;
         cnt        <= '0;
         pulse_idx  <= '0;
         run_cycles <= '0;
         halted     <= 1'b0;
         timeout    <= 1'b0;
      end else begin
         case (state)
            S_ASSERT: begin
               if (cnt == len_last) begin
                  cnt   <= '0;
                  state <= (pulse_idx < LAST_PULSE) ? S_GAP : S_RUN;
               end else begin
                  cnt <= cnt + ONE;
               end
            end
            S_GAP: begin
               if (cnt == GAP_LAST) begin
                  cnt       <= '0;
                  pulse_idx <= pulse_idx + ONE;
                  state     <= S_ASSERT;
               end else begin
                  cnt <= cnt + ONE;
               end
            end
            S_RUN: begin
               cnt <= cnt + ONE;
               if (run_cycles != '1) run_cycles <= run_cycles + ONE;
               // Halt takes priority over window expiry on the same cycle.
               if (halt_i) begin
                  state  <= S_DONE;
                  halted <= 1'b1;
               end else if (cnt == RUN_LAST) begin
                  state   <= S_DONE;
                  timeout <= 1'b1;
               end
            end
            S_DONE: begin
               if (rerun_i) begin
                  state      <= S_ASSERT;
                  cnt        <= '0;
                  pulse_idx  <= '0;
                  run_cycles <= '0;
                  halted     <= 1'b0;
                  timeout    <= 1'b0;
               end
            end
            default: state <= S_ASSERT;
         endcase
      end
   end

   assign dut_rst = (state == S_ASSERT) ? RST_POL : ~RST_POL;
   assign phase   = state;
   assign done    = (state == S_DONE);

endmodule
